// File: rtl/uart_sys_ctrl_pkg.sv
// Shared constants for the UART command controller: opcodes, FSM state encoding
// and the fixed register-file addresses used for ALU operands.
package uart_sys_pkg;

   localparam logic [7:0] CMD_RF_WR   = 8'hAA;
   localparam logic [7:0] CMD_RF_RD   = 8'hBB;
   localparam logic [7:0] CMD_ALU_OP  = 8'hCC;
   localparam logic [7:0] CMD_ALU_NOP = 8'hDD;

   localparam int OP_A_ADDR = 0;
   localparam int OP_B_ADDR = 1;

   typedef enum logic [3:0] {
      IDLE      = 4'd0,
      WR_ADDR   = 4'd1,
      WR_DATA   = 4'd2,
      RD_ADDR   = 4'd3,
      RD_WAIT   = 4'd4,
      OP_A      = 4'd5,
      OP_B      = 4'd6,
      ALU_FUN_S = 4'd7,
      ALU_WAIT  = 4'd8,
      TX_LO     = 4'd9,
      TX_HI     = 4'd10
   } state_e;

endpackage

// File: rtl/uart_sys_ctrl_if.sv
// Bundle of the controller's RX, register-file, ALU and TX FIFO signals.
// The slave modport is the controller's view; master is the surrounding system.
interface uart_sys_ctrl_if #(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 4,
   parameter int FUN_WIDTH  = 4
);
   logic [DATA_WIDTH-1:0]   RX_P_DATA;
   logic                    RX_D_VLD;
   logic [DATA_WIDTH-1:0]   RF_RD_DATA;
   logic                    RF_RD_DATA_VLD;
   logic [2*DATA_WIDTH-1:0] ALU_OUT;
   logic                    ALU_OUT_VLD;
   logic                    FIFO_FULL;
   logic                    RF_WR_EN;
   logic                    RF_RD_EN;
   logic [ADDR_WIDTH-1:0]   RF_ADDR;
   logic [DATA_WIDTH-1:0]   RF_WR_DATA;
   logic                    ALU_EN;
   logic [FUN_WIDTH-1:0]    ALU_FUN;
   logic                    CLK_GATE_EN;
   logic [DATA_WIDTH-1:0]   TX_P_DATA;
   logic                    TX_D_VLD;

   modport master (
      output RX_P_DATA, RX_D_VLD, RF_RD_DATA, RF_RD_DATA_VLD, ALU_OUT, ALU_OUT_VLD, FIFO_FULL,
      input  RF_WR_EN, RF_RD_EN, RF_ADDR, RF_WR_DATA, ALU_EN, ALU_FUN, CLK_GATE_EN,
             TX_P_DATA, TX_D_VLD
   );

   modport slave (
      input  RX_P_DATA, RX_D_VLD, RF_RD_DATA, RF_RD_DATA_VLD, ALU_OUT, ALU_OUT_VLD, FIFO_FULL,
      output RF_WR_EN, RF_RD_EN, RF_ADDR, RF_WR_DATA, ALU_EN, ALU_FUN, CLK_GATE_EN,
             TX_P_DATA, TX_D_VLD
   );
endinterface

// File: rtl/uart_sys_ctrl.sv
// Command controller: parses RX command packets, sequences register-file and ALU
// operations, and returns response bytes to the TX FIFO. All outputs registered.
//
// state     | meaning
// IDLE      | waiting for an opcode byte
// WR_ADDR   | RF write: waiting for address byte
// WR_DATA   | RF write: waiting for data byte
// RD_ADDR   | RF read: waiting for address byte
// RD_WAIT   | RF read issued, waiting for read data
// OP_A      | ALU: waiting for operand A (written to RF addr 0)
// OP_B      | ALU: waiting for operand B (written to RF addr 1)
// ALU_FUN_S | ALU: waiting for function byte, ALU clock enabled
// ALU_WAIT  | ALU started, waiting for result
// TX_LO     | sending response low byte
// TX_HI     | sending response high byte
module uart_sys_ctrl
   import uart_sys_pkg::*;
#(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 4,
   parameter int FUN_WIDTH  = 4
) (
   input logic CLK,
   input logic RST,
   uart_sys_ctrl_if.slave bus
);

   state_e                  r_state, w_state_nxt;
   logic [2*DATA_WIDTH-1:0] r_rsp, w_rsp_nxt;
   logic                    r_two, w_two_nxt;
   logic                    r_rf_wr_en, w_rf_wr_en_nxt;
   logic                    r_rf_rd_en, w_rf_rd_en_nxt;
   logic [ADDR_WIDTH-1:0]   r_rf_addr, w_rf_addr_nxt;
   logic [DATA_WIDTH-1:0]   r_rf_wr_data, w_rf_wr_data_nxt;
   logic                    r_alu_en, w_alu_en_nxt;
   logic [FUN_WIDTH-1:0]    r_alu_fun, w_alu_fun_nxt;
   logic                    r_gate, w_gate_nxt;
   logic [DATA_WIDTH-1:0]   r_tx_data, w_tx_data_nxt;
   logic                    r_tx_vld, w_tx_vld_nxt;

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         r_state      <= IDLE;
         r_rsp        <= '0;
         r_two        <= 1'b0;
         r_rf_wr_en   <= 1'b0;
         r_rf_rd_en   <= 1'b0;
         r_rf_addr    <= '0;
         r_rf_wr_data <= '0;
         r_alu_en     <= 1'b0;
         r_alu_fun    <= '0;
         r_gate       <= 1'b0;
         r_tx_data    <= '0;
         r_tx_vld     <= 1'b0;
      end else begin
         r_state      <= w_state_nxt;
         r_rsp        <= w_rsp_nxt;
         r_two        <= w_two_nxt;
         r_rf_wr_en   <= w_rf_wr_en_nxt;
         r_rf_rd_en   <= w_rf_rd_en_nxt;
         r_rf_addr    <= w_rf_addr_nxt;
         r_rf_wr_data <= w_rf_wr_data_nxt;
         r_alu_en     <= w_alu_en_nxt;
         r_alu_fun    <= w_alu_fun_nxt;
         r_gate       <= w_gate_nxt;
         r_tx_data    <= w_tx_data_nxt;
         r_tx_vld     <= w_tx_vld_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE: begin
            if (bus.RX_D_VLD) begin
               case (bus.RX_P_DATA)
                  CMD_RF_WR:   w_state_nxt = WR_ADDR;
                  CMD_RF_RD:   w_state_nxt = RD_ADDR;
                  CMD_ALU_OP:  w_state_nxt = OP_A;
                  CMD_ALU_NOP: w_state_nxt = ALU_FUN_S;
                  default:     w_state_nxt = IDLE;
               endcase
            end
         end
         WR_ADDR:   if (bus.RX_D_VLD)       w_state_nxt = WR_DATA;
         WR_DATA:   if (bus.RX_D_VLD)       w_state_nxt = IDLE;
         RD_ADDR:   if (bus.RX_D_VLD)       w_state_nxt = RD_WAIT;
         RD_WAIT:   if (bus.RF_RD_DATA_VLD) w_state_nxt = TX_LO;
         OP_A:      if (bus.RX_D_VLD)       w_state_nxt = OP_B;
         OP_B:      if (bus.RX_D_VLD)       w_state_nxt = ALU_FUN_S;
         ALU_FUN_S: if (bus.RX_D_VLD)       w_state_nxt = ALU_WAIT;
         ALU_WAIT:  if (bus.ALU_OUT_VLD)    w_state_nxt = TX_LO;
         TX_LO:     if (!bus.FIFO_FULL)     w_state_nxt = r_two ? TX_HI : IDLE;
         TX_HI:     if (!bus.FIFO_FULL)     w_state_nxt = IDLE;
         default:                           w_state_nxt = IDLE;
      endcase
   end

   // Next values of the registered outputs; data outputs hold between strobes.
   always_comb begin
      w_rsp_nxt        = r_rsp;
      w_two_nxt        = r_two;
      w_rf_wr_en_nxt   = 1'b0;
      w_rf_rd_en_nxt   = 1'b0;
      w_rf_addr_nxt    = r_rf_addr;
      w_rf_wr_data_nxt = r_rf_wr_data;
      w_alu_en_nxt     = 1'b0;
      w_alu_fun_nxt    = r_alu_fun;
      w_tx_data_nxt    = r_tx_data;
      w_tx_vld_nxt     = 1'b0;
      w_gate_nxt       = (w_state_nxt == ALU_FUN_S) || (w_state_nxt == ALU_WAIT);
      case (r_state)
         WR_ADDR: if (bus.RX_D_VLD) w_rf_addr_nxt = bus.RX_P_DATA[ADDR_WIDTH-1:0];
         WR_DATA: if (bus.RX_D_VLD) begin
            w_rf_wr_en_nxt   = 1'b1;
            w_rf_wr_data_nxt = bus.RX_P_DATA;
         end
         RD_ADDR: if (bus.RX_D_VLD) begin
            w_rf_rd_en_nxt = 1'b1;
            w_rf_addr_nxt  = bus.RX_P_DATA[ADDR_WIDTH-1:0];
         end
         RD_WAIT: if (bus.RF_RD_DATA_VLD) begin
            w_rsp_nxt = {{DATA_WIDTH{1'b0}}, bus.RF_RD_DATA};
            w_two_nxt = 1'b0;
         end
         OP_A, OP_B: if (bus.RX_D_VLD) begin
            w_rf_wr_en_nxt   = 1'b1;
            w_rf_addr_nxt    = (r_state == OP_A) ? ADDR_WIDTH'(OP_A_ADDR) : ADDR_WIDTH'(OP_B_ADDR);
            w_rf_wr_data_nxt = bus.RX_P_DATA;
         end
         ALU_FUN_S: if (bus.RX_D_VLD) begin
            w_alu_en_nxt  = 1'b1;
            w_alu_fun_nxt = bus.RX_P_DATA[FUN_WIDTH-1:0];
         end
         ALU_WAIT: if (bus.ALU_OUT_VLD) begin
            w_rsp_nxt = bus.ALU_OUT;
            w_two_nxt = 1'b1;
         end
         TX_LO: if (!bus.FIFO_FULL) begin
            w_tx_vld_nxt  = 1'b1;
            w_tx_data_nxt = r_rsp[DATA_WIDTH-1:0];
         end
         TX_HI: if (!bus.FIFO_FULL) begin
            w_tx_vld_nxt  = 1'b1;
            w_tx_data_nxt = r_rsp[2*DATA_WIDTH-1:DATA_WIDTH];
         end
         default: ;
      endcase
   end

   assign bus.RF_WR_EN    = r_rf_wr_en;
   assign bus.RF_RD_EN    = r_rf_rd_en;
   assign bus.RF_ADDR     = r_rf_addr;
   assign bus.RF_WR_DATA  = r_rf_wr_data;
   assign bus.ALU_EN      = r_alu_en;
   assign bus.ALU_FUN     = r_alu_fun;
   assign bus.CLK_GATE_EN = r_gate;
   assign bus.TX_P_DATA   = r_tx_data;
   assign bus.TX_D_VLD    = r_tx_vld;

endmodule

// File: tb/tb_uart_sys_ctrl.sv
// Directed bench for uart_sys_ctrl: stimulus pushes expected strobe events into a
// queue, a monitor pops and compares each DUT strobe as it appears.
module tb_uart_sys_ctrl;

   logic CLK = 1'b0;
   logic RST = 1'b0;

   uart_sys_ctrl_if bus();

   uart_sys_ctrl dut (
      .CLK (CLK),
      .RST (RST),
      .bus (bus)
   );

   always #5 CLK = ~CLK;

   typedef struct packed {
      logic [1:0] kind;
      logic [7:0] a;
      logic [7:0] b;
   } ev_t;

   localparam logic [1:0] EV_WR  = 2'd0;
   localparam logic [1:0] EV_RD  = 2'd1;
   localparam logic [1:0] EV_ALU = 2'd2;
   localparam logic [1:0] EV_TX  = 2'd3;

   ev_t exp_q[$];
   int  checks = 0;
   int  errors = 0;

   function automatic ev_t mk(logic [1:0] k, logic [7:0] a, logic [7:0] b);
      ev_t e;
      e.kind = k;
      e.a    = a;
      e.b    = b;
      return e;
   endfunction

   function automatic logic [31:0] outs();
      return {3'b000, bus.RF_WR_EN, bus.RF_RD_EN, bus.RF_ADDR, bus.RF_WR_DATA, bus.ALU_EN,
              bus.ALU_FUN, bus.CLK_GATE_EN, bus.TX_P_DATA, bus.TX_D_VLD};
   endfunction

   task automatic chk(string name, logic [31:0] act, logic [31:0] expv);
      checks++;
      if (act !== expv) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, expv);
      end
   endtask

   task automatic cmp_ev(ev_t act);
      ev_t e;
      checks++;
      if (exp_q.size() == 0) begin
         errors++;
         $display("FAIL unexpected_event actual=%h required=none", act);
      end else begin
         e = exp_q.pop_front();
         if (act !== e) begin
            errors++;
            $display("FAIL event actual=%h required=%h", act, e);
         end
      end
   endtask

   initial begin
      forever begin
         @(posedge CLK);
         #1;
         if (RST) begin
            if (bus.RF_WR_EN) cmp_ev(mk(EV_WR, {4'h0, bus.RF_ADDR}, bus.RF_WR_DATA));
            if (bus.RF_RD_EN) cmp_ev(mk(EV_RD, {4'h0, bus.RF_ADDR}, 8'h00));
            if (bus.ALU_EN)   cmp_ev(mk(EV_ALU, {4'h0, bus.ALU_FUN}, 8'h00));
            if (bus.TX_D_VLD) begin
               cmp_ev(mk(EV_TX, bus.TX_P_DATA, 8'h00));
               chk("tx_while_full", {31'd0, bus.FIFO_FULL}, 32'd0);
            end
         end
      end
   end

   task automatic send(logic [7:0] b);
      @(negedge CLK);
      bus.RX_P_DATA = b;
      bus.RX_D_VLD  = 1'b1;
      @(negedge CLK);
      bus.RX_D_VLD  = 1'b0;
   endtask

   task automatic pulse_rd(logic [7:0] d);
      @(negedge CLK);
      bus.RF_RD_DATA     = d;
      bus.RF_RD_DATA_VLD = 1'b1;
      @(negedge CLK);
      bus.RF_RD_DATA_VLD = 1'b0;
   endtask

   task automatic pulse_alu(logic [15:0] d);
      @(negedge CLK);
      bus.ALU_OUT     = d;
      bus.ALU_OUT_VLD = 1'b1;
      @(negedge CLK);
      bus.ALU_OUT_VLD = 1'b0;
   endtask

   task automatic drain(string name);
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 200) begin
         @(negedge CLK);
         n++;
      end
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL %s_timeout pending=%0d required=0", name, exp_q.size());
         exp_q.delete();
      end
      repeat (4) @(negedge CLK);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog actual=running required=finished");
      $fatal(1, "watchdog expired");
   end

   initial begin
      bus.RX_P_DATA      = '0;
      bus.RX_D_VLD       = 1'b0;
      bus.RF_RD_DATA     = '0;
      bus.RF_RD_DATA_VLD = 1'b0;
      bus.ALU_OUT        = '0;
      bus.ALU_OUT_VLD    = 1'b0;
      bus.FIFO_FULL      = 1'b0;
      repeat (3) @(negedge CLK);
      chk("reset_outputs", outs(), 32'd0);
      RST = 1'b1;
      repeat (2) @(negedge CLK);

      // RF write
      exp_q.push_back(mk(EV_WR, 8'h05, 8'h3C));
      send(8'hAA); send(8'h05); send(8'h3C);
      drain("rf_write");

      // illegal opcode and stray result pulses in IDLE
      send(8'h55);
      pulse_alu(16'h1234);
      pulse_rd(8'h99);
      repeat (5) @(negedge CLK);
      chk("idle_gate", {31'd0, bus.CLK_GATE_EN}, 32'd0);

      // RF read with a dropped byte and FIFO backpressure
      exp_q.push_back(mk(EV_RD, 8'h02, 8'h00));
      exp_q.push_back(mk(EV_TX, 8'h7E, 8'h00));
      bus.FIFO_FULL = 1'b1;
      send(8'hBB); send(8'h02);
      send(8'hCC);
      pulse_rd(8'h7E);
      repeat (5) @(negedge CLK);
      chk("read_held_pending", exp_q.size(), 32'd1);
      bus.FIFO_FULL = 1'b0;
      drain("rf_read");

      // ALU with operands
      exp_q.push_back(mk(EV_WR, 8'h00, 8'h10));
      exp_q.push_back(mk(EV_WR, 8'h01, 8'h20));
      exp_q.push_back(mk(EV_ALU, 8'h01, 8'h00));
      exp_q.push_back(mk(EV_TX, 8'h30, 8'h00));
      exp_q.push_back(mk(EV_TX, 8'h00, 8'h00));
      send(8'hCC); send(8'h10);
      chk("gate_op_b", {31'd0, bus.CLK_GATE_EN}, 32'd0);
      send(8'h20);
      chk("gate_fun", {31'd0, bus.CLK_GATE_EN}, 32'd1);
      send(8'h01);
      repeat (3) @(negedge CLK);
      chk("gate_wait", {31'd0, bus.CLK_GATE_EN}, 32'd1);
      pulse_alu(16'h0030);
      chk("gate_after_result", {31'd0, bus.CLK_GATE_EN}, 32'd0);
      drain("alu_op");

      // ALU without operands
      exp_q.push_back(mk(EV_ALU, 8'h02, 8'h00));
      exp_q.push_back(mk(EV_TX, 8'hEF, 8'h00));
      exp_q.push_back(mk(EV_TX, 8'hBE, 8'h00));
      send(8'hDD);
      chk("gate_nop", {31'd0, bus.CLK_GATE_EN}, 32'd1);
      send(8'h02);
      pulse_alu(16'hBEEF);
      drain("alu_nop");

      // reset mid-packet, then a clean write
      exp_q.push_back(mk(EV_WR, 8'h00, 8'h11));
      send(8'hCC); send(8'h11);
      drain("pre_reset");
      @(negedge CLK);
      RST = 1'b0;
      #1;
      chk("reset_mid_packet", outs(), 32'd0);
      @(negedge CLK);
      RST = 1'b1;
      exp_q.push_back(mk(EV_WR, 8'h03, 8'h09));
      send(8'hAA); send(8'h03); send(8'h09);
      drain("post_reset_write");

      chk("queue_empty", exp_q.size(), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
